// File: rtl/matrix_pkg.sv
// Constants and types shared by the matrix unit and the consumers of its result bus.
package matrix_pkg;

    localparam int ELEM_W = 16;
    localparam int N_ELEM = 64;
    localparam int IDX_W  = $clog2(N_ELEM);

    localparam logic [ELEM_W-1:0] SAT_VALUE = {ELEM_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/vec_elem_mux.sv
// Pure N_ELEM:1 element select; element i occupies bits [i*EW +: EW] of the vector.
module vec_elem_mux
    import matrix_pkg::*;
#(
    parameter int EW = ELEM_W,
    parameter int NE = N_ELEM,
    parameter int IW = IDX_W
) (
    input  logic [NE*EW-1:0] vec,
    input  logic [IW-1:0]    sel,
    output logic [EW-1:0]    elem
);

    assign elem = vec[sel*EW +: EW];

endmodule

// File: rtl/vec_result_streamer.sv
// Captures a wide result vector on load and streams it one element per valid/ready
// handshake, tagging each beat with its index, last and saturation flags.
module vec_result_streamer
    import matrix_pkg::*;
#(
    parameter int EW = ELEM_W,
    parameter int NE = N_ELEM,
    parameter int IW = IDX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [NE*EW-1:0]   datsIn,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EW-1:0]      out_data,
    output logic [IW-1:0]      out_index,
    output logic               out_last,
    output logic               out_sat,
    output logic               done,
    output logic               overrun,
    input  logic               clr_overrun
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

    stream_state_e     state_r;
    logic [NE*EW-1:0]  shadow_r;
    logic [IW-1:0]     idx_r;
    logic              done_r;
    logic              overrun_r;

    logic              streaming_s;
    logic              at_last_s;
    logic              last_hs_s;
    logic              load_rejected_s;

    assign streaming_s     = (state_r == STREAM);
    assign at_last_s       = (idx_r == LAST_IDX);
    assign last_hs_s       = streaming_s && out_ready && at_last_s;
    assign load_rejected_s = streaming_s && load && !last_hs_s;

    // Stream FSM: element counter, shadow capture and the end-of-vector done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            shadow_r <= {(NE*EW){1'b0}};
            idx_r    <= {IW{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        shadow_r <= datsIn;
                        idx_r    <= {IW{1'b0}};
                        state_r  <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (at_last_s) begin
                            done_r <= 1'b1;
                            idx_r  <= {IW{1'b0}};
                            // A load on the final handshake chains the next vector with no bubble.
                            if (load) begin
                                shadow_r <= datsIn;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {IW{1'b0}};
                end
            endcase
        end
    end

    // Sticky overrun flag: a rejected load wins over a clear in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (load_rejected_s) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    vec_elem_mux #(
        .EW (EW),
        .NE (NE),
        .IW (IW)
    ) u_elem_mux (
        .vec  (shadow_r),
        .sel  (idx_r),
        .elem (out_data)
    );

    assign busy      = streaming_s;
    assign out_valid = streaming_s;
    assign out_index = idx_r;
    assign out_last  = at_last_s;
    assign out_sat   = (out_data == {EW{1'b1}});
    assign done      = done_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_vec_result_streamer.sv
// Directed bench for vec_result_streamer: a scenario table plus hand sequences.
module tb_vec_result_streamer;
    import matrix_pkg::*;

    logic                     clock;
    logic                     reset;
    logic                     load;
    logic [N_ELEM*ELEM_W-1:0] datsIn;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [ELEM_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;
    logic                     out_sat;
    logic                     done;
    logic                     overrun;
    logic                     clr_overrun;

    int vectors;
    int miscompares;
    logic ovr_exp;

    vec_result_streamer dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .datsIn      (datsIn),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .out_sat     (out_sat),
        .done        (done),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string      name;
        int         fill;
        logic [3:0] pat;
        int         load_beat;
        bit         clr_with_load;
        bit         load_last;
        int         next_fill;
    } scen_t;

    function automatic logic [ELEM_W-1:0] elem_of(input int fill, input int i);
        case (fill)
            0: elem_of = 16'h0100 + 16'(i);
            1: elem_of = 16'hAAAA;
            2: elem_of = (i == 5 || i == 63) ? 16'hFFFF : 16'h0000;
            3: elem_of = 16'h3000 + 16'(i * 7);
            default: elem_of = 16'h5555;
        endcase
    endfunction

    function automatic logic [N_ELEM*ELEM_W-1:0] make_vec(input int fill);
        logic [N_ELEM*ELEM_W-1:0] v;
        for (int i = 0; i < N_ELEM; i++) v[i*ELEM_W +: ELEM_W] = elem_of(fill, i);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_vec(input int fill);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        datsIn = make_vec(fill);
        load = 1'b1;
        out_ready = 1'b0;
        tick();
        load = 1'b0;
    endtask

    // Streams one vector from beat 0, checking every cycle; expects out_valid already high.
    task automatic stream_vector(input int fill, input logic [3:0] pat, input int load_beat,
                                 input bit clr_with_load, input bit load_last, input int next_fill);
        int beat = 0;
        int cyc = 0;
        bit injected = 1'b0;
        bit ovr_pending;
        logic rdy;
        logic [ELEM_W-1:0] e;
        while (beat < N_ELEM && cyc < 1000) begin
            load = 1'b0;
            clr_overrun = 1'b0;
            ovr_pending = 1'b0;
            e = elem_of(fill, beat);
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("index", 32'(out_index), 32'(beat));
            chk("data", 32'(out_data), 32'(e));
            chk("last", 32'(out_last), 32'(beat == N_ELEM - 1));
            chk("sat", 32'(out_sat), 32'(e == 16'hFFFF));
            chk("overrun", 32'(overrun), 32'(ovr_exp));
            if (cyc > 0) chk("done_mid", 32'(done), 32'd0);
            rdy = pat[cyc % 4];
            out_ready = rdy;
            if (beat == load_beat && !injected) begin
                injected = 1'b1;
                load = 1'b1;
                datsIn = make_vec(4);
                clr_overrun = clr_with_load;
                ovr_pending = 1'b1;
            end
            if (rdy && beat == N_ELEM - 1 && load_last) begin
                load = 1'b1;
                datsIn = make_vec(next_fill);
            end
            if (rdy) beat++;
            cyc++;
            tick();
            if (ovr_pending) ovr_exp = 1'b1;
        end
        load = 1'b0;
        clr_overrun = 1'b0;
        out_ready = 1'b0;
        chk("beats", 32'(beat), 32'(N_ELEM));
        chk("done_pulse", 32'(done), 32'd1);
        if (!load_last) begin
            chk("end_valid", 32'(out_valid), 32'd0);
            chk("end_busy", 32'(busy), 32'd0);
            tick();
            chk("done_once", 32'(done), 32'd0);
        end
    endtask

    scen_t tbl[5];

    initial begin
        vectors = 0;
        miscompares = 0;
        ovr_exp = 1'b0;
        reset = 1'b0;
        load = 1'b0;
        datsIn = '0;
        out_ready = 1'b0;
        clr_overrun = 1'b0;

        tbl[0] = '{"single",      0, 4'b1111, -1, 1'b0, 1'b0, 0};
        tbl[1] = '{"backpress",   0, 4'b1001, -1, 1'b0, 1'b0, 0};
        tbl[2] = '{"saturation",  2, 4'b1111, -1, 1'b0, 1'b0, 0};
        tbl[3] = '{"overrun",     0, 4'b1111, 10, 1'b0, 1'b0, 0};
        tbl[4] = '{"ovr_vs_clr",  0, 4'b1011, 10, 1'b1, 1'b0, 0};

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        #19 reset = 1'b1;
        tick();

        for (int s = 0; s < 5; s++) begin
            load_vec(tbl[s].fill);
            stream_vector(tbl[s].fill, tbl[s].pat, tbl[s].load_beat, tbl[s].clr_with_load,
                          tbl[s].load_last, tbl[s].next_fill);
            clr_overrun = 1'b1;
            tick();
            clr_overrun = 1'b0;
            ovr_exp = 1'b0;
            chk({tbl[s].name, "_clr"}, 32'(overrun), 32'd0);
        end

        // Back-to-back: B is loaded on A's final handshake and must follow without a bubble.
        load_vec(0);
        stream_vector(0, 4'b1111, -1, 1'b0, 1'b1, 1);
        stream_vector(1, 4'b1111, -1, 1'b0, 1'b0, 0);
        chk("b2b_overrun", 32'(overrun), 32'd0);

        // Reset mid-stream: the vector is discarded, no done, and a new vector starts cleanly.
        load_vec(0);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("pre_rst_index", 32'(out_index), 32'd20);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_index", 32'(out_index), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        tick();
        chk("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        out_ready = 1'b0;
        ovr_exp = 1'b0;
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        load_vec(3);
        stream_vector(3, 4'b0111, -1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
